// File: rtl/pipe3_pkg.sv
// Shared definitions for the pipe3 core: instruction field positions, ALU opcodes,
// stage control structs and the opcode decoder.
package pipe3_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RA_W    = 5;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned WS_HI  = 25;
    localparam int unsigned WS_LO  = 21;
    localparam int unsigned RS1_HI = 20;
    localparam int unsigned RS1_LO = 16;
    localparam int unsigned RS2_HI = 15;
    localparam int unsigned RS2_LO = 11;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    // opcode bit selecting the immediate as operand B, and bit forcing a NOP
    localparam int unsigned OP_IMM = 4;
    localparam int unsigned OP_NOP = 5;

    typedef enum logic [3:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_AND = 4'h3,
        ALU_OR  = 4'h4,
        ALU_XOR = 4'h5,
        ALU_SLL = 4'h6,
        ALU_SRL = 4'h7,
        ALU_SRA = 4'h8,
        ALU_SLT = 4'h9,
        ALU_MOV = 4'hA
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        alu_op_e         op;
        logic [RA_W-1:0] ws;
    } s2_ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] ws;
    } s3_ctrl_t;

    // Map a 6-bit opcode onto an ALU operation; reserved codes become NOP.
    function automatic alu_op_e decode_op(input logic [5:0] opc);
        alu_op_e op;
        op = ALU_NOP;
        if (!opc[OP_NOP]) begin
            case (opc[3:0])
                4'h1:    op = ALU_ADD;
                4'h2:    op = ALU_SUB;
                4'h3:    op = ALU_AND;
                4'h4:    op = ALU_OR;
                4'h5:    op = ALU_XOR;
                4'h6:    op = ALU_SLL;
                4'h7:    op = ALU_SRL;
                4'h8:    op = ALU_SRA;
                4'h9:    op = ALU_SLT;
                4'hA:    op = ALU_MOV;
                default: op = ALU_NOP;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/pipe3_if.sv
// Instruction-in / result-out bus of the pipe3 core; the core uses the slave modport.
interface pipe3_if #(
    parameter int unsigned DATA_W = 32
);
    import pipe3_pkg::*;

    logic                in_valid;
    logic [INSTR_W-1:0]  in_instr;
    logic                in_ready;
    logic                hold;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [RA_W-1:0]     out_ws;

    modport master (
        output in_valid, in_instr, hold,
        input  in_ready, out_valid, out_data, out_ws
    );

    modport slave (
        input  in_valid, in_instr, hold,
        output in_ready, out_valid, out_data, out_ws
    );

endinterface

// File: rtl/pipe3_regfile.sv
// Architectural register file: two async read ports, one write port, r0 fixed at zero.
// Addresses at or beyond NREGS read as zero and their writes are dropped.
module pipe3_regfile
    import pipe3_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [DATA_W-1:0] regs [NREGS];

    function automatic logic live_addr(input logic [RA_W-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (we && live_addr(waddr)) begin
            regs[AW'(waddr)] <= wdata;
        end
    end

    assign rdata_a = live_addr(raddr_a) ? regs[AW'(raddr_a)] : '0;
    assign rdata_b = live_addr(raddr_b) ? regs[AW'(raddr_b)] : '0;

endmodule

// File: rtl/pipe3_core.sv
// Three-stage integer pipeline (decode/read, execute, result/write-back).
// Define PIPE3_FWD_EN for the operand bypass network; otherwise RAW hazards interlock.
module pipe3_core
    import pipe3_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input logic    clk,
    input logic    rst,
    pipe3_if.slave bus
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic               s1_valid;
    logic [INSTR_W-1:0] s1_instr;
    s2_ctrl_t           s2;
    logic [DATA_W-1:0]  s2_a;
    logic [DATA_W-1:0]  s2_b;
    s3_ctrl_t           s3;
    logic [DATA_W-1:0]  s3_data;

    logic [5:0]         s1_opc;
    alu_op_e            s1_op;
    logic               s1_live;
    logic               s1_use_rs2;
    logic [RA_W-1:0]    s1_ws;
    logic [RA_W-1:0]    s1_rs1;
    logic [RA_W-1:0]    s1_rs2;
    logic [DATA_W-1:0]  s1_imm;

    logic [DATA_W-1:0]  rf_a;
    logic [DATA_W-1:0]  rf_b;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_rs2;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W-1:0]  alu_res;
    logic [SH_W-1:0]    shamt;
    logic               interlock;
    logic               advance;

    // S1 decode; NOP forms never enter S2 as valid work
    assign s1_opc     = s1_instr[OPC_HI:OPC_LO];
    assign s1_op      = decode_op(s1_opc);
    assign s1_live    = s1_valid && (s1_op != ALU_NOP);
    assign s1_use_rs2 = !s1_opc[OP_IMM];
    assign s1_ws      = s1_instr[WS_HI:WS_LO];
    assign s1_rs1     = s1_instr[RS1_HI:RS1_LO];
    assign s1_rs2     = s1_instr[RS2_HI:RS2_LO];
    assign s1_imm     = DATA_W'($signed(s1_instr[IMM_HI:IMM_LO]));

    pipe3_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (s3.valid),
        .waddr   (s3.ws),
        .wdata   (s3_data),
        .raddr_a (s1_rs1),
        .rdata_a (rf_a),
        .raddr_b (s1_rs2),
        .rdata_b (rf_b)
    );

`ifdef PIPE3_FWD_EN
    // Youngest producer wins: S2 ALU output, then S3 result, then the register file.
    always_comb begin
        op_a = rf_a;
        if (s1_rs1 == '0)                         op_a = '0;
        else if (s2.valid && (s2.ws == s1_rs1))   op_a = alu_res;
        else if (s3.valid && (s3.ws == s1_rs1))   op_a = s3_data;

        op_rs2 = rf_b;
        if (s1_rs2 == '0)                         op_rs2 = '0;
        else if (s2.valid && (s2.ws == s1_rs2))   op_rs2 = alu_res;
        else if (s3.valid && (s3.ws == s1_rs2))   op_rs2 = s3_data;
    end

    assign interlock = 1'b0;
`else
    logic hit_a;
    logic hit_b;

    assign op_a   = rf_a;
    assign op_rs2 = rf_b;

    // A source still owned by S2 or S3 must wait until its write-back has landed.
    assign hit_a = (s1_rs1 != '0) &&
                   ((s2.valid && (s2.ws == s1_rs1)) || (s3.valid && (s3.ws == s1_rs1)));
    assign hit_b = (s1_rs2 != '0) &&
                   ((s2.valid && (s2.ws == s1_rs2)) || (s3.valid && (s3.ws == s1_rs2)));
    assign interlock = s1_live && (hit_a || (s1_use_rs2 && hit_b));
`endif

    assign op_b    = s1_use_rs2 ? op_rs2 : s1_imm;
    assign advance = !bus.hold && !interlock;

    // S2 execute
    assign shamt = s2_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (s2.op)
            ALU_ADD: alu_res = s2_a + s2_b;
            ALU_SUB: alu_res = s2_a - s2_b;
            ALU_AND: alu_res = s2_a & s2_b;
            ALU_OR:  alu_res = s2_a | s2_b;
            ALU_XOR: alu_res = s2_a ^ s2_b;
            ALU_SLL: alu_res = s2_a << shamt;
            ALU_SRL: alu_res = s2_a >> shamt;
            ALU_SRA: alu_res = $signed(s2_a) >>> shamt;
            ALU_SLT: alu_res = DATA_W'($signed(s2_a) < $signed(s2_b));
            ALU_MOV: alu_res = s2_b;
            default: alu_res = '0;
        endcase
    end

    // Hold freezes S1/S2 and drains S3; interlock freezes S1 and bubbles S2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s2       <= '0;
            s2_a     <= '0;
            s2_b     <= '0;
            s3       <= '0;
            s3_data  <= '0;
        end else if (bus.hold) begin
            s3.valid <= 1'b0;
        end else begin
            if (advance) begin
                s1_valid <= bus.in_valid;
                s1_instr <= bus.in_instr;
                s2.valid <= s1_live;
                s2.op    <= s1_op;
                s2.ws    <= s1_ws;
                s2_a     <= op_a;
                s2_b     <= op_b;
            end else begin
                s2.valid <= 1'b0;
            end
            s3.valid <= s2.valid;
            s3.ws    <= s2.ws;
            s3_data  <= alu_res;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = s3.valid;
    assign bus.out_data  = s3_data;
    assign bus.out_ws    = s3.ws;

endmodule

// File: tb/tb_pipe3_core.sv
// Directed bench for pipe3_core: a 32-bit/32-register instance and a 16-bit/8-register instance.
module tb_pipe3_core;
    import pipe3_pkg::*;

`ifdef PIPE3_FWD_EN
    localparam int STALL = 0;
`else
    localparam int STALL = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe3_if #(.DATA_W(32)) b32 ();
    pipe3_if #(.DATA_W(16)) b16 ();

    pipe3_core #(.DATA_W(32), .NREGS(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    pipe3_core #(.DATA_W(16), .NREGS(8))  u_dut16 (.clk(clk), .rst(rst), .bus(b16));

    typedef struct {
        logic [63:0] data;
        logic [4:0]  ws;
        int          stamp;
    } res_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] exp;
        logic [4:0]  ws;
        bit          out;
    } vec_t;

    res_t q32[$];
    res_t q16[$];
    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // result monitor, sampled mid-cycle
    always @(negedge clk) begin
        res_t r;
        if (b32.out_valid === 1'b1) begin
            r.data = 64'(b32.out_data); r.ws = b32.out_ws; r.stamp = cyc;
            q32.push_back(r);
        end
        if (b16.out_valid === 1'b1) begin
            r.data = 64'(b16.out_data); r.ws = b16.out_ws; r.stamp = cyc;
            q16.push_back(r);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] opc, input int ws, input int rs1, input int rs2);
        return {opc, 5'(ws), 5'(rs1), 5'(rs2), 11'b0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] opc, input int ws, input int rs1, input logic [15:0] imm);
        return {opc, 5'(ws), 5'(rs1), imm};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction and return the cycle stamp of its accepting edge.
    task automatic send(input bit sel, input logic [31:0] instr, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        if (sel) begin b16.in_valid = 1'b1; b16.in_instr = instr; end
        else     begin b32.in_valid = 1'b1; b32.in_instr = instr; end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if ((sel ? b16.in_ready : b32.in_ready) === 1'b1) begin ok = 1'b1; break; end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            acc = cyc;
        end else begin
            n_total++;
            $display("FAIL accept: instr 0x%08h never accepted, required acceptance within 40 cycles", instr);
        end
        b16.in_valid = 1'b0;
        b32.in_valid = 1'b0;
    endtask

    task automatic pop_check(input bit sel, input string name, input logic [63:0] data,
                             input logic [4:0] ws, output int stamp);
        res_t r;
        stamp = -1;
        if ((sel ? q16.size() : q32.size()) == 0) begin
            n_total++;
            $display("FAIL %s: no result, expected data 0x%0h ws %0d", name, data, ws);
            return;
        end
        r = sel ? q16.pop_front() : q32.pop_front();
        stamp = r.stamp;
        check({name, ".data"}, r.data, data);
        check({name, ".ws"}, 64'(r.ws), 64'(ws));
    endtask

    task automatic add(input logic [31:0] ins, input logic [63:0] exp, input int ws, input bit out);
        vec_t v;
        v.instr = ins; v.exp = exp; v.ws = 5'(ws); v.out = out;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input bit sel, input string name);
        int acc;
        int st;
        if (sel) q16.delete(); else q32.delete();
        foreach (tbl[i]) send(sel, tbl[i].instr, acc);
        idle(10);
        foreach (tbl[i]) begin
            if (tbl[i].out) pop_check(sel, $sformatf("%s[%0d]", name, i), tbl[i].exp, tbl[i].ws, st);
        end
        check({name, ".extra"}, 64'(sel ? q16.size() : q32.size()), 64'd0);
        tbl.delete();
    endtask

    initial begin
        int a0, a1, a2, s0, s1, s2, lowcnt;

        rst = 1'b0;
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.hold = 1'b0;
        b16.in_valid = 1'b0; b16.in_instr = '0; b16.hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("reset.out_valid", 64'(b32.out_valid), 64'd0);
        check("reset.out_data",  64'(b32.out_data),  64'd0);
        check("reset.out_ws",    64'(b32.out_ws),    64'd0);
        check("reset.in_ready",  64'(b32.in_ready),  64'd1);
        check("reset16.in_ready", 64'(b16.in_ready), 64'd1);
        @(posedge clk); #1;

        // back-to-back RAW: ADDI r1,5; ADDI r2,7; ADD r3,r1,r2
        q32.delete();
        send(0, i_ins(6'h11, 1, 0, 16'd5), a0);
        send(0, i_ins(6'h11, 2, 0, 16'd7), a1);
        send(0, r_ins(6'h01, 3, 1, 2), a2);
        lowcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b32.in_ready !== 1'b1) lowcnt++;
            @(posedge clk); #1;
        end
        idle(4);
        check("raw.accept2", 64'(a1 - a0), 64'd1);
        check("raw.accept3", 64'(a2 - a0), 64'd2);
        check("raw.stall_cycles", 64'(lowcnt), 64'(STALL));
        pop_check(0, "raw.r1", 64'd5, 5'd1, s0);
        check("raw.r1_latency", 64'(s0 - a0), 64'd2);
        pop_check(0, "raw.r2", 64'd7, 5'd2, s1);
        check("raw.r2_cycle", 64'(s1 - a0), 64'd3);
        pop_check(0, "raw.r3", 64'd12, 5'd3, s2);
        check("raw.r3_cycle", 64'(s2 - a0), 64'(4 + STALL));
        check("raw.extra", 64'(q32.size()), 64'd0);

        // ALU table at DATA_W=32
        add(i_ins(6'h11,  4,  0, 16'hFFFF), 64'hFFFFFFFF,  4, 1);
        add(i_ins(6'h18,  5,  4, 16'd4),    64'hFFFFFFFF,  5, 1);
        add(i_ins(6'h17,  6,  4, 16'd28),   64'h0000000F,  6, 1);
        add(r_ins(6'h09,  7,  4,  0),       64'h00000001,  7, 1);
        add(i_ins(6'h11,  8,  0, 16'h1234), 64'h00001234,  8, 1);
        add(r_ins(6'h02,  9,  8,  6),       64'h00001225,  9, 1);
        add(r_ins(6'h03, 10,  8,  4),       64'h00001234, 10, 1);
        add(i_ins(6'h14, 11,  8, 16'h00F0), 64'h000012F4, 11, 1);
        add(i_ins(6'h15, 12,  8, 16'hFFFF), 64'hFFFFEDCB, 12, 1);
        add(i_ins(6'h16, 13,  6, 16'd28),   64'hF0000000, 13, 1);
        add(r_ins(6'h0A, 14,  0,  9),       64'h00001225, 14, 1);
        add(i_ins(6'h1A, 15,  0, 16'h8000), 64'hFFFF8000, 15, 1);
        add(i_ins(6'h12, 16,  0, 16'd1),    64'hFFFFFFFF, 16, 1);
        add(r_ins(6'h01, 17,  4,  4),       64'hFFFFFFFE, 17, 1);
        add(r_ins(6'h09, 18,  0,  4),       64'h00000000, 18, 1);
        add(r_ins(6'h0B, 19,  4,  4),       64'h0,        19, 0);
        add(r_ins(6'h21, 19,  4,  4),       64'h0,        19, 0);
        add(i_ins(6'h11,  0,  0, 16'd9),    64'h00000009,  0, 1);
        add(r_ins(6'h01,  1,  0,  0),       64'h00000000,  1, 1);
        add(r_ins(6'h07, 19, 12,  6),       64'h0001FFFF, 19, 1);
        add(i_ins(6'h16, 20,  8, 16'h0021), 64'h00002468, 20, 1);
        run_tbl(0, "alu32");

        // hold with three instructions in flight
        q32.delete();
        send(0, i_ins(6'h11, 21, 0, 16'h11), a0);
        send(0, i_ins(6'h11, 22, 0, 16'h22), a0);
        send(0, i_ins(6'h11, 23, 0, 16'h33), a0);
        b32.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold.in_ready[%0d]", i), 64'(b32.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        b32.hold = 1'b0;
        idle(6);
        pop_check(0, "hold.i1", 64'h11, 5'd21, s0);
        pop_check(0, "hold.i2", 64'h22, 5'd22, s0);
        pop_check(0, "hold.i3", 64'h33, 5'd23, s0);
        check("hold.extra", 64'(q32.size()), 64'd0);
        send(0, r_ins(6'h01, 24, 21, 23), a0);
        idle(8);
        pop_check(0, "hold.wb", 64'h44, 5'd24, s0);

        // reset with three instructions in flight
        send(0, i_ins(6'h11, 25, 0, 16'h55), a0);
        send(0, i_ins(6'h11, 26, 0, 16'h66), a0);
        send(0, i_ins(6'h11, 27, 0, 16'h77), a0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst.out_valid", 64'(b32.out_valid), 64'd0);
        check("midrst.out_data",  64'(b32.out_data),  64'd0);
        check("midrst.out_ws",    64'(b32.out_ws),    64'd0);
        rst = 1'b1;
        q32.delete();
        q16.delete();
        @(posedge clk); #1;
        send(0, r_ins(6'h0A, 1, 0, 5), a0);
        idle(8);
        pop_check(0, "midrst.mov", 64'd0, 5'd1, s0);
        check("midrst.extra", 64'(q32.size()), 64'd0);

        // DATA_W=16, NREGS=8
        add(i_ins(6'h11, 1, 0, 16'h7FFF), 64'h7FFF, 1, 1);
        add(i_ins(6'h11, 1, 1, 16'd1),    64'h8000, 1, 1);
        add(r_ins(6'h09, 2, 1, 0),        64'h0001, 2, 1);
        add(i_ins(6'h11, 9, 0, 16'd5),    64'h0005, 9, 1);
        add(r_ins(6'h01, 4, 1, 1),        64'h0000, 4, 1);
        add(i_ins(6'h18, 5, 1, 16'd15),   64'hFFFF, 5, 1);
        add(i_ins(6'h17, 6, 1, 16'h0013), 64'h1000, 6, 1);
        add(r_ins(6'h0A, 7, 0, 2),        64'h0001, 7, 1);
        run_tbl(1, "alu16");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe3_core.md
# pipe3_core

Parametrised three-stage integer pipeline: decode register, register-file read with operand bypass, ALU execute, result register with write-back. It succeeds the fixed 32-bit pipeline core with configurable datapath width, a valid/ready input handshake, a global hold, and selectable forwarding or interlock hazard handling. It sits between the instruction source and any result consumer; `out_data` mirrors the write-back bus.

## Interface
- `DATA_W`, 32, datapath and register width; legal range 16..64.
- `NREGS`, 32, number of architectural registers; legal range 2..32, addressed by 5-bit fields; register 0 reads as zero.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  `in_instr` is valid this cycle.
- `in_instr`  in  32  instruction word.
- `in_ready`  out  1  instruction accepted on this edge if `in_valid` is high.
- `hold`  in  1  freeze S1/S2, retire S3.
- `out_valid`  out  1  S3 holds a retired non-NOP result.
- `out_data`  out  DATA_W  S3 result.
- `out_ws`  out  5  S3 destination register.

## Operation
- Encoding:
  - `[31:26]` opcode
  - `[25:21]` ws
  - `[20:16]` rs1
  - `[15:11]` rs2
  - `[15:0]` imm, sign-extended to DATA_W
- opcode[4] set selects the immediate as operand B. opcode[5] set decodes as NOP.
- opcode[3:0] operations:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLL
  - 7 SRL
  - 8 SRA
  - 9 SLT (signed, result 0/1)
  - A MOV (result = B)
  - B..F NOP
- Arithmetic wraps modulo 2^DATA_W. Shift amount is B[$clog2(DATA_W)-1:0].
- Stages:
  - S1 = accepted instruction.
  - S2 = operands A/B, op, ws, valid.
  - S3 = result, ws, valid.
- Every non-NOP writes `ws` at the edge after it occupies S3. Writes to r0 and to ws ≥ NREGS are dropped, but still reported on `out_*`.
- Bypass priority for each S1 source: r0 → 0, else S2 ALU result (valid, ws match), else S3 result (valid, ws match), else register file.
- `in_ready` = !hold && !interlock. A non-accepted cycle with advancing S1 loads a bubble.
- `hold`=1:
  - S1 and S2 retain their contents.
  - S3 loads a bubble; its prior content still writes back on that edge.
  - Each result appears on `out_valid` exactly once.
- Reset clears:
  - all stage valids
  - `out_valid`, `out_data`, `out_ws` to 0
  - all registers to 0
- `in_ready` is 1 after reset. Reset mid-stream discards in-flight instructions.

## Timing
- Instruction accepted at edge E0 is in S1 after E0, S2 after E1, S3 after E2. `out_valid`/`out_data` are valid in the cycle after E2, and the register file is updated at E3.
- With forwarding, throughput is one instruction per cycle with zero stalls for any dependency.
- Simultaneous S3 write and S1 read of the same register returns the S3 value.

## Configuration
- `PIPE3_FWD_EN` defined: bypass network as above, no interlock.
- Undefined: no bypass. The S1 source (rs1, and rs2 for register forms, r0 excluded) matching a valid S2 or S3 ws raises interlock:
  - S1 holds and S2 loads a bubble.
  - A dependency on S2 costs 2 stall cycles; on S3, 1 cycle.
  - Results are identical, only later.

## Structure
- `pipe3_pkg`:
  - opcode constants
  - field bit positions
  - the `OP_IMM` bit
  - the S2/S3 stage struct typedefs
- Sub-module `pipe3_regfile`:
  - NREGS × DATA_W
  - two async read ports, one write port
  - async active-low clear
  - r0 hardwired to zero

## Test plan
- Reset: drive rst low mid-stream with 3 instructions in flight → `out_valid`=0, `out_data`=0, `out_ws`=0; afterwards MOV r1,r5 yields 0.
- Back-to-back RAW, forwarding: ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2 → `out_data` 5,7,12 on consecutive cycles starting the cycle after E2.
- Back-to-back RAW, without `PIPE3_FWD_EN`: same program → 12 appears 2 cycles later and `in_ready` is low for 2 cycles.
- Shifts at DATA_W=32: ADDI r4,r0,0xFFFF → 0xFFFFFFFF; SRA r5,r4 by 4 → 0xFFFFFFFF; SRL r6,r4 by 28 → 0xF; SLT r7,r4,r0 → 1.
- Hold: 3 cycles of hold with 3 instructions in flight → `in_ready`=0; each result emitted exactly once, in order; no duplicates after release.
- r0 and width: ADDI r0,r0,9 → `out_data`=9, `out_ws`=0; ADD r1,r0,r0 → 0. At DATA_W=16: ADDI r1,r0,0x7FFF; ADDI r1,r1,1 → 0x8000; SLT r2,r1,r0 → 1.
